// File: rtl/snoop_responder.sv
// snoop_responder: answers snoop bus operations (READ/WRITE/INVALIDATE/RWIM)
// issued by other caches. It probes the local tag/state directory, returns
// NO_HIT/HIT/HIT_M, flushes a modified line when the requester needs the
// data, and writes back the resulting MESI state.
// Latency: accept T, dir_req T+1, rslt_valid T+2, upd_valid T+3, ready T+4
// (plus directory-ack wait and flush stall cycles). One snoop in flight.
// Backpressure: snp_ready is low from LOOKUP through UPDATE. dir_req is held
// until dir_ack. wb_valid/wb_addr are held until wb_ready.
// Ports:
//   clk, rst_n                            clock, async active-low reset
//   snp_valid/snp_ready/snp_op/snp_addr   snoop request handshake
//   dir_req/dir_set/dir_tag               directory lookup request
//   dir_ack/dir_hit/dir_way/dir_state     directory lookup response
//   rslt_valid/rslt                       snoop result strobe
//   wb_valid/wb_addr/wb_ready             modified-line flush request
//   upd_valid/upd_set/upd_way/upd_state   MESI state update strobe
// Optional build macro SNOOP_STATS_EN adds saturating HIT / HIT_M counters
// on the stat_hit / stat_hitm outputs.

package snoop_responder_pkg;
   typedef enum logic [1:0] {
      BUS_READ       = 2'd0,
      BUS_WRITE      = 2'd1,
      BUS_INVALIDATE = 2'd2,
      BUS_RWIM       = 2'd3
   } bus_op_t;

   typedef enum logic [1:0] {
      SNP_NO_HIT = 2'd0,
      SNP_HIT    = 2'd1,
      SNP_HIT_M  = 2'd2
   } snp_rslt_t;

   typedef enum logic [1:0] {
      ST_M = 2'd0,
      ST_E = 2'd1,
      ST_S = 2'd2,
      ST_I = 2'd3
   } state_t;
endpackage

module snoop_responder
   import snoop_responder_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int BYTE_W = 6,
   parameter int SET_W  = 15,
   parameter int TAG_W  = 11,
   parameter int WAY_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              snp_valid,
   output logic              snp_ready,
   input  logic [1:0]        snp_op,
   input  logic [ADDR_W-1:0] snp_addr,
   output logic              dir_req,
   output logic [SET_W-1:0]  dir_set,
   output logic [TAG_W-1:0]  dir_tag,
   input  logic              dir_ack,
   input  logic              dir_hit,
   input  logic [WAY_W-1:0]  dir_way,
   input  logic [1:0]        dir_state,
   output logic              rslt_valid,
   output logic [1:0]        rslt,
   output logic              wb_valid,
   output logic [ADDR_W-1:0] wb_addr,
   input  logic              wb_ready,
   output logic              upd_valid,
   output logic [SET_W-1:0]  upd_set,
   output logic [WAY_W-1:0]  upd_way,
   output logic [1:0]        upd_state
`ifdef SNOOP_STATS_EN
   ,
   output logic [15:0]       stat_hit,
   output logic [15:0]       stat_hitm
`endif
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOOKUP  = 3'd1,
      RESPOND = 3'd2,
      FLUSH   = 3'd3,
      UPDATE  = 3'd4
   } fsm_t;

   // Clears the byte-select bits to form the line-aligned flush address.
   localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-BYTE_W){1'b1}}, {BYTE_W{1'b0}}};

   // A miss or an invalid line reports NO_HIT regardless of dir_state.
   function automatic logic [1:0] classify(input logic hit, input logic [1:0] st);
      if (!hit || st == ST_I) begin
         return SNP_NO_HIT;
      end else if (st == ST_M) begin
         return SNP_HIT_M;
      end else begin
         return SNP_HIT;
      end
   endfunction

   // MESI next state as seen by the snooped cache. WRITE never changes
   // the local state; a miss or an I line keeps its old state.
   function automatic logic [1:0] next_mesi(input logic [1:0] op, input logic hit,
                                            input logic [1:0] old);
      if (!hit || old == ST_I) begin
         return old;
      end
      case (op)
         BUS_READ:       return ST_S;
         BUS_RWIM:       return ST_I;
         BUS_INVALIDATE: return ST_I;
         default:        return old;
      endcase
   endfunction

   fsm_t              state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              hit_q, hit_d;
   logic [WAY_W-1:0]  way_q, way_d;
   logic [1:0]        old_q, old_d;

   logic              snp_ready_q, snp_ready_d;
   logic              dir_req_q, dir_req_d;
   logic [SET_W-1:0]  dir_set_q, dir_set_d;
   logic [TAG_W-1:0]  dir_tag_q, dir_tag_d;
   logic              rslt_valid_q, rslt_valid_d;
   logic [1:0]        rslt_q, rslt_d;
   logic              wb_valid_q, wb_valid_d;
   logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
   logic              upd_valid_q, upd_valid_d;
   logic [SET_W-1:0]  upd_set_q, upd_set_d;
   logic [WAY_W-1:0]  upd_way_q, upd_way_d;
   logic [1:0]        upd_state_q, upd_state_d;

   logic [1:0]        new_state;
   logic              need_flush;

   assign new_state  = next_mesi(op_q, hit_q, old_q);
   // Only the requester that wants the data (READ/RWIM) triggers a flush;
   // INVALIDATE on an M line drops the data, WRITE leaves the line alone.
   assign need_flush = (rslt_q == SNP_HIT_M) && (op_q == BUS_READ || op_q == BUS_RWIM);

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      addr_d       = addr_q;
      hit_d        = hit_q;
      way_d        = way_q;
      old_d        = old_q;
      snp_ready_d  = 1'b0;
      dir_req_d    = 1'b0;
      dir_set_d    = dir_set_q;
      dir_tag_d    = dir_tag_q;
      rslt_valid_d = 1'b0;
      rslt_d       = rslt_q;
      wb_valid_d   = 1'b0;
      wb_addr_d    = wb_addr_q;
      upd_valid_d  = 1'b0;
      upd_set_d    = upd_set_q;
      upd_way_d    = upd_way_q;
      upd_state_d  = upd_state_q;

      case (state_q)
         IDLE: begin
            snp_ready_d = 1'b1;
            if (snp_valid && snp_ready_q) begin
               op_d        = snp_op;
               addr_d      = snp_addr;
               dir_req_d   = 1'b1;
               dir_set_d   = snp_addr[BYTE_W +: SET_W];
               dir_tag_d   = snp_addr[ADDR_W-1 -: TAG_W];
               snp_ready_d = 1'b0;
               state_d     = LOOKUP;
            end
         end

         LOOKUP: begin
            if (dir_ack) begin
               hit_d        = dir_hit;
               way_d        = dir_way;
               old_d        = dir_state;
               rslt_valid_d = 1'b1;
               rslt_d       = classify(dir_hit, dir_state);
               state_d      = RESPOND;
            end else begin
               dir_req_d = 1'b1;
            end
         end

         RESPOND: begin
            if (need_flush) begin
               wb_valid_d = 1'b1;
               wb_addr_d  = addr_q & LINE_MASK;
               state_d    = FLUSH;
            end else begin
               upd_valid_d = (new_state != old_q);
               upd_set_d   = addr_q[BYTE_W +: SET_W];
               upd_way_d   = way_q;
               upd_state_d = new_state;
               state_d     = UPDATE;
            end
         end

         FLUSH: begin
            // wb_valid is already high throughout FLUSH, so wb_ready alone
            // completes the handshake.
            if (wb_ready) begin
               upd_valid_d = (new_state != old_q);
               upd_set_d   = addr_q[BYTE_W +: SET_W];
               upd_way_d   = way_q;
               upd_state_d = new_state;
               state_d     = UPDATE;
            end else begin
               wb_valid_d = 1'b1;
            end
         end

         UPDATE: begin
            snp_ready_d = 1'b1;
            state_d     = IDLE;
         end

         default: begin
            snp_ready_d = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         op_q         <= '0;
         addr_q       <= '0;
         hit_q        <= 1'b0;
         way_q        <= '0;
         old_q        <= '0;
         snp_ready_q  <= 1'b1;
         dir_req_q    <= 1'b0;
         dir_set_q    <= '0;
         dir_tag_q    <= '0;
         rslt_valid_q <= 1'b0;
         rslt_q       <= '0;
         wb_valid_q   <= 1'b0;
         wb_addr_q    <= '0;
         upd_valid_q  <= 1'b0;
         upd_set_q    <= '0;
         upd_way_q    <= '0;
         upd_state_q  <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         hit_q        <= hit_d;
         way_q        <= way_d;
         old_q        <= old_d;
         snp_ready_q  <= snp_ready_d;
         dir_req_q    <= dir_req_d;
         dir_set_q    <= dir_set_d;
         dir_tag_q    <= dir_tag_d;
         rslt_valid_q <= rslt_valid_d;
         rslt_q       <= rslt_d;
         wb_valid_q   <= wb_valid_d;
         wb_addr_q    <= wb_addr_d;
         upd_valid_q  <= upd_valid_d;
         upd_set_q    <= upd_set_d;
         upd_way_q    <= upd_way_d;
         upd_state_q  <= upd_state_d;
      end
   end

   assign snp_ready  = snp_ready_q;
   assign dir_req    = dir_req_q;
   assign dir_set    = dir_set_q;
   assign dir_tag    = dir_tag_q;
   assign rslt_valid = rslt_valid_q;
   assign rslt       = rslt_q;
   assign wb_valid   = wb_valid_q;
   assign wb_addr    = wb_addr_q;
   assign upd_valid  = upd_valid_q;
   assign upd_set    = upd_set_q;
   assign upd_way    = upd_way_q;
   assign upd_state  = upd_state_q;

`ifdef SNOOP_STATS_EN
   logic [15:0] stat_hit_q, stat_hit_d;
   logic [15:0] stat_hitm_q, stat_hitm_d;

   // Counted at the end of the rslt_valid cycle; both saturate.
   always_comb begin
      stat_hit_d  = stat_hit_q;
      stat_hitm_d = stat_hitm_q;
      if (rslt_valid_q && rslt_q == SNP_HIT && stat_hit_q != 16'hFFFF) begin
         stat_hit_d = stat_hit_q + 16'd1;
      end
      if (rslt_valid_q && rslt_q == SNP_HIT_M && stat_hitm_q != 16'hFFFF) begin
         stat_hitm_d = stat_hitm_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_hit_q  <= '0;
         stat_hitm_q <= '0;
      end else begin
         stat_hit_q  <= stat_hit_d;
         stat_hitm_q <= stat_hitm_d;
      end
   end

   assign stat_hit  = stat_hit_q;
   assign stat_hitm = stat_hitm_q;
`endif

endmodule
